// File: rtl/qlearn_pkg.sv
// Shared Q-learning definitions: Q8.8 value type, constants and the
// state encoding of the max-Q scanner. Also used by the updater and the Q-table.
package qlearn_pkg;

  localparam int Q_WIDTH = 16;
  localparam int Q_FRAC  = 8;

  typedef logic signed [Q_WIDTH-1:0] q_t;

  // Most-negative Q8.8 value; seeds every running-max search.
  localparam q_t Q_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } qmax_state_t;

endpackage

// File: rtl/qmax_cmp.sv
// Registered running-maximum element.
// Keeps the best (value, index) pair seen since the last clear. Only a strictly
// greater value replaces the best one, so ties keep the earliest (lowest) index.
// The first valid entry after a clear always wins, even if it equals the seed.
// o_next_* expose the value the registers take at the coming edge, so a
// consumer can capture the final result in the same cycle as the last sample.
module qmax_cmp #(
  parameter int VAL_WIDTH = 16,
  parameter int IDX_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_clear,
  input  logic                        i_valid,
  input  logic signed [VAL_WIDTH-1:0] i_value,
  input  logic        [IDX_WIDTH-1:0] i_index,
  output logic signed [VAL_WIDTH-1:0] o_best_q,
  output logic        [IDX_WIDTH-1:0] o_best_idx,
  output logic signed [VAL_WIDTH-1:0] o_next_q,
  output logic        [IDX_WIDTH-1:0] o_next_idx
);

  // Most-negative value of the configured width.
  localparam logic signed [VAL_WIDTH-1:0] SEED = {1'b1, {(VAL_WIDTH-1){1'b0}}};

  logic signed [VAL_WIDTH-1:0] r_best_q;
  logic        [IDX_WIDTH-1:0] r_best_idx;
  logic                        r_empty;
  logic                        w_take;

  // Decide whether the incoming sample replaces the current best.
  always_comb begin
    w_take     = i_valid && (r_empty || (i_value > r_best_q));
    o_next_q   = w_take ? i_value : r_best_q;
    o_next_idx = w_take ? i_index : r_best_idx;
  end

  // Hold the running best; clear reseeds it for a new row.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_best_q   <= SEED;
      r_best_idx <= '0;
      r_empty    <= 1'b1;
    end else if (i_clear) begin
      r_best_q   <= SEED;
      r_best_idx <= '0;
      r_empty    <= 1'b1;
    end else if (w_take) begin
      r_best_q   <= i_value;
      r_best_idx <= i_index;
      r_empty    <= 1'b0;
    end
  end

  assign o_best_q   = r_best_q;
  assign o_best_idx = r_best_idx;

endmodule

// File: rtl/qmax_finder.sv
// qmax_finder: scans one state's row of the Q-table and returns max_a Q(s',a)
// together with the argmax action.
// Timeline for a start accepted at edge T: addresses {s', 0..N-1} are issued in
// cycles T+1..T+N, the last read data is consumed in T+N+1, and done pulses in
// T+N+2 with the result. Q values are signed Q8.8.
// Optional build macro QMAX_TERMINAL_EN adds a 'terminal' input: a terminal
// next state skips the scan and reports max_q = 0, max_action = 0 at T+1.
module qmax_finder
  import qlearn_pkg::*;
#(
  parameter int Q_WIDTH      = 16,
  parameter int N_ACTIONS    = 4,
  parameter int STATE_WIDTH  = 4,
  parameter int ACTION_WIDTH = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [STATE_WIDTH-1:0]              next_state,
`ifdef QMAX_TERMINAL_EN
  input  logic                                terminal,
`endif
  output logic                                busy,
  output logic                                rd_en,
  output logic [STATE_WIDTH+ACTION_WIDTH-1:0] rd_addr,
  input  logic [Q_WIDTH-1:0]                  rd_data,
  output logic [Q_WIDTH-1:0]                  max_q,
  output logic [ACTION_WIDTH-1:0]             max_action,
  output logic                                done
);

  localparam logic [ACTION_WIDTH-1:0] LAST_ACTION = ACTION_WIDTH'(N_ACTIONS - 1);

  qmax_state_t                 r_state;
  logic [STATE_WIDTH-1:0]      r_state_lat;
  logic [ACTION_WIDTH-1:0]     r_cnt;
  logic                        r_busy;
  logic                        r_rd_en;
  logic [STATE_WIDTH+ACTION_WIDTH-1:0] r_rd_addr;
  logic                        r_vld_d;
  logic [ACTION_WIDTH-1:0]     r_idx_d;
  logic [Q_WIDTH-1:0]          r_max_q;
  logic [ACTION_WIDTH-1:0]     r_max_action;
  logic                        r_done;

  logic                        w_term;
  logic                        w_accept;
  logic                        w_clear;
  logic signed [Q_WIDTH-1:0]   w_rd_value;
  logic signed [Q_WIDTH-1:0]   w_best_q;
  logic [ACTION_WIDTH-1:0]     w_best_idx;
  logic signed [Q_WIDTH-1:0]   w_next_q;
  logic [ACTION_WIDTH-1:0]     w_next_idx;

`ifdef QMAX_TERMINAL_EN
  assign w_term = terminal;
`else
  assign w_term = 1'b0;
`endif

  // A request is only honoured from IDLE; anything else is dropped.
  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_clear    = w_accept && !w_term;
  assign w_rd_value = $signed(rd_data);

  qmax_cmp #(
    .VAL_WIDTH (Q_WIDTH),
    .IDX_WIDTH (ACTION_WIDTH)
  ) u_cmp (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_clear),
    .i_valid    (r_vld_d),
    .i_value    (w_rd_value),
    .i_index    (r_idx_d),
    .o_best_q   (w_best_q),
    .o_best_idx (w_best_idx),
    .o_next_q   (w_next_q),
    .o_next_idx (w_next_idx)
  );

  // Scan sequencer: issues one read per action, then publishes the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_state_lat  <= '0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
      r_vld_d      <= 1'b0;
      r_idx_d      <= '0;
      r_max_q      <= '0;
      r_max_action <= '0;
      r_done       <= 1'b0;
    end else begin
      // Read data returns one cycle after the strobe; tag it with its action.
      r_vld_d <= r_rd_en;
      r_idx_d <= r_cnt;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state_lat <= next_state;
            r_cnt       <= '0;
            if (w_term) begin
              // Terminal next state: no future value, report zero at once.
              r_state      <= S_DONE;
              r_done       <= 1'b1;
              r_max_q      <= '0;
              r_max_action <= '0;
            end else begin
              r_state   <= S_ISSUE;
              r_busy    <= 1'b1;
              r_rd_en   <= 1'b1;
              r_rd_addr <= {next_state, {ACTION_WIDTH{1'b0}}};
            end
          end
        end
        S_ISSUE: begin
          if (r_cnt == LAST_ACTION) begin
            r_rd_en <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_cnt     <= r_cnt + 1'b1;
            r_rd_addr <= {r_state_lat, r_cnt + 1'b1};
          end
        end
        S_DRAIN: begin
          // The last sample is compared this cycle; take the post-compare best.
          r_state      <= S_DONE;
          r_busy       <= 1'b0;
          r_done       <= 1'b1;
          r_max_q      <= w_next_q;
          r_max_action <= w_next_idx;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign rd_en      = r_rd_en;
  assign rd_addr    = r_rd_addr;
  assign max_q      = r_max_q;
  assign max_action = r_max_action;
  assign done       = r_done;

endmodule
